// File: rtl/commit_arbiter.sv
// commit_arbiter: round-robin grant of one reservation-station commit per cycle
// onto the shared commit bus, with a one-cycle mask on the last winner.
`ifndef COMMIT_PACKET_SIZE
`define COMMIT_PACKET_SIZE 32
`endif
module commit_arbiter #(
  parameter int NUM_RS   = 4,
  parameter int PACKET_W = `COMMIT_PACKET_SIZE,
  parameter int CNT_W    = 16
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [NUM_RS-1:0]          iRequest,
  input  logic [NUM_RS*PACKET_W-1:0] iPacket,
  input  logic                       iStall,
  output logic [NUM_RS-1:0]          oGrant,
  output logic [PACKET_W:0]          oCommitBus,
  output logic [3:0]                 oCommitSrc,
  output logic [CNT_W-1:0]           oCommitCount
);
  logic [3:0]          r_pointer;
  logic [NUM_RS-1:0]   r_last_grant;
  logic [NUM_RS-1:0]   w_elig;
  logic [NUM_RS-1:0]   w_onehot;
  logic                w_hi;
  logic                w_lo;
  logic                w_go;
  logic [3:0]          w_hi_idx;
  logic [3:0]          w_lo_idx;
  logic [3:0]          w_win;
  logic [PACKET_W-1:0] w_pkt;
  // Descending scan leaves the lowest eligible index overall (w_lo) and the
  // lowest at/after the pointer (w_hi); the latter wins, else wrap to w_lo.
  always_comb begin
    w_elig   = iRequest & ~r_last_grant;
    w_hi     = 1'b0;
    w_lo     = 1'b0;
    w_hi_idx = 4'd0;
    w_lo_idx = 4'd0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_lo     = 1'b1;
        w_lo_idx = 4'(i);
        if (i >= int'(r_pointer)) begin
          w_hi     = 1'b1;
          w_hi_idx = 4'(i);
        end
      end
    end
    w_win    = w_hi ? w_hi_idx : w_lo_idx;
    w_go     = w_lo && !iStall;
    w_onehot = NUM_RS'(1) << w_win;
    w_pkt    = '0;
    for (int i = 0; i < NUM_RS; i++)
      if (w_win == 4'(i)) w_pkt = iPacket[i*PACKET_W +: PACKET_W];
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oGrant       <= '0;
      oCommitBus   <= '0;
      oCommitSrc   <= '0;
      oCommitCount <= '0;
      r_pointer    <= '0;
      r_last_grant <= '0;
    end else begin
      oGrant               <= w_go ? w_onehot : '0;
      r_last_grant         <= w_go ? w_onehot : '0;
      oCommitBus[PACKET_W] <= w_go;
      if (w_go) begin
        oCommitBus[PACKET_W-1:0] <= w_pkt;
        oCommitSrc               <= w_win;
        r_pointer                <= (w_win == 4'(NUM_RS - 1)) ? 4'd0 : w_win + 4'd1;
        oCommitCount             <= oCommitCount + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_commit_arbiter.sv
// tb_commit_arbiter: randomized stations against a behavioural round-robin model,
// plus directed reset, stall, single-requester, wrap-search and counter-wrap cases.
module tb_commit_arbiter;
  localparam int N = 4;
  localparam int PW = 8;
  localparam int CW = 4;
  logic          Clock = 1'b0;
  logic          Reset;
  logic [N-1:0]  iRequest;
  logic [N*PW-1:0] iPacket;
  logic          iStall;
  logic [N-1:0]  oGrant;
  logic [PW:0]   oCommitBus;
  logic [3:0]    oCommitSrc;
  logic [CW-1:0] oCommitCount;
  commit_arbiter #(.NUM_RS(N), .PACKET_W(PW), .CNT_W(CW)) dut (
    .Clock(Clock), .Reset(Reset), .iRequest(iRequest), .iPacket(iPacket),
    .iStall(iStall), .oGrant(oGrant), .oCommitBus(oCommitBus),
    .oCommitSrc(oCommitSrc), .oCommitCount(oCommitCount)
  );
  always #5 Clock = ~Clock;
  logic          st_req [N];
  logic [PW-1:0] st_pkt [N];
  int            st_wait [N];
  logic auto_on, rnd_on;
  int g_seen;
  int m_ptr, m_last, m_cnt, m_src, m_grant, ngr;
  logic m_valid;
  logic [PW-1:0] m_pkt;
  int n_vec, n_err;
  always_comb begin
    iRequest = {st_req[3], st_req[2], st_req[1], st_req[0]};
    iPacket  = {st_pkt[3], st_pkt[2], st_pkt[1], st_pkt[0]};
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic m_reset();
    m_ptr = 0; m_last = -1; m_cnt = 0; m_src = 0; m_grant = -1;
    m_valid = 1'b0; m_pkt = '0; g_seen = -1; ngr = 0;
  endtask
  // Reference: scan stations starting at the pointer, skipping last winner.
  task automatic model_edge();
    int w;
    w = -1;
    if (!iStall)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (w < 0 && st_req[j] && j != m_last) w = j;
      end
    m_grant = w;
    if (w >= 0) begin
      m_valid = 1'b1; m_pkt = st_pkt[w]; m_src = w; m_last = w;
      m_ptr = (w + 1) % N; m_cnt = (m_cnt + 1) % (1 << CW); ngr++;
    end else begin
      m_valid = 1'b0; m_last = -1;
    end
  endtask
  task automatic check_all();
    chk("grant", 32'(oGrant), (m_grant >= 0) ? 32'(1) << m_grant : 32'd0);
    chk("bus", 32'(oCommitBus), 32'({m_valid, m_pkt}));
    chk("src", 32'(oCommitSrc), 32'(m_src));
    chk("count", 32'(oCommitCount), 32'(m_cnt));
  endtask
  task automatic stations();
    if (!auto_on) return;
    for (int i = 0; i < N; i++) begin
      if (st_req[i] && g_seen == i) begin
        st_req[i] = 1'b0;
        st_wait[i] = rnd_on ? int'($urandom_range(0, 3)) : 1;
      end else if (!st_req[i]) begin
        if (st_wait[i] == 0) begin
          st_req[i] = 1'b1;
          st_pkt[i] = PW'($urandom);
        end else st_wait[i]--;
      end
    end
    if (rnd_on) iStall = ($urandom_range(0, 4) == 0);
  endtask
  task automatic step();
    model_edge();
    @(posedge Clock);
    #1;
    check_all();
    stations();
    g_seen = m_grant;
  endtask
  task automatic rst_dut();
    #2 Reset = 1'b0;
    m_reset();
    #1 check_all();
    @(negedge Clock);
    Reset = 1'b1;
  endtask
  initial begin
    n_vec = 0; n_err = 0;
    auto_on = 1'b0; rnd_on = 1'b0; iStall = 1'b0;
    for (int i = 0; i < N; i++) begin
      st_req[i] = 1'b1; st_pkt[i] = PW'(8'h10 + i); st_wait[i] = 0;
    end
    Reset = 1'b0;
    m_reset();
    repeat (3) @(posedge Clock);
    #1 check_all();
    chk("rst_grant", 32'(oGrant), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    auto_on = 1'b1;
    step();
    chk("first_grant", 32'(oGrant), 32'b0001);
    chk("first_count", 32'(oCommitCount), 32'd1);
    repeat (20) step();
    // Asynchronous reset mid-cycle with stations still requesting.
    rst_dut();
    repeat (10) step();
    auto_on = 1'b0;
    for (int i = 0; i < N; i++) st_req[i] = 1'b0;
    repeat (2) step();
    rst_dut();
    st_req[1] = 1'b1; st_req[2] = 1'b1; iStall = 1'b1;
    repeat (5) step();
    chk("stall_count", 32'(oCommitCount), 32'd0);
    iStall = 1'b0;
    step();
    chk("stall_g1", 32'(oGrant), 32'b0010);
    step();
    chk("stall_g2", 32'(oGrant), 32'b0100);
    for (int i = 0; i < N; i++) st_req[i] = 1'b0;
    repeat (2) step();
    st_req[2] = 1'b1; st_pkt[2] = 8'hA5;
    step();
    chk("single_g", 32'(oGrant), 32'b0100);
    chk("single_bus", 32'(oCommitBus), 32'h1A5);
    step();
    chk("single_mask", 32'(oGrant), 32'd0);
    chk("single_valid", 32'(oCommitBus[PW]), 32'd0);
    st_req[2] = 1'b0;
    step();
    st_req[0] = 1'b1; st_req[1] = 1'b1; st_pkt[0] = 8'h3C; st_pkt[1] = 8'hC3;
    step();
    chk("wrap_g0", 32'(oGrant), 32'b0001);
    step();
    chk("wrap_g1", 32'(oGrant), 32'b0010);
    for (int i = 0; i < N; i++) st_req[i] = 1'b0;
    repeat (2) step();
    auto_on = 1'b1; rnd_on = 1'b1;
    for (int t = 0; t < 1500; t++) begin
      if (t == 700) rst_dut();
      step();
    end
    rnd_on = 1'b0; iStall = 1'b0;
    rst_dut();
    for (int t = 0; t < 200 && ngr < 17; t++) step();
    chk("cnt_grants", 32'(ngr), 32'd17);
    chk("cnt_wrap", 32'(oCommitCount), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
